// File: rtl/mdu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : mdu_ctrl_pkg
// Brief  : Shared MDU decode constants, state/op encodings and timing defaults
// Rev    : 1.0  initial release
// ============================================================================
package mdu_ctrl_pkg;

   localparam int c_MULT_CYC_DEF = 5;
   localparam int c_DIV_CYC_DEF  = 10;

   localparam logic [5:0] c_OP_SPECIAL = 6'b000000;
   localparam logic [5:0] c_FN_MULT    = 6'b011000;
   localparam logic [5:0] c_FN_MULTU   = 6'b011001;
   localparam logic [5:0] c_FN_DIV     = 6'b011010;
   localparam logic [5:0] c_FN_DIVU    = 6'b011011;
   localparam logic [5:0] c_FN_MFHI    = 6'b010000;
   localparam logic [5:0] c_FN_MTHI    = 6'b010001;
   localparam logic [5:0] c_FN_MFLO    = 6'b010010;
   localparam logic [5:0] c_FN_MTLO    = 6'b010011;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MULT = 2'd1,
      ST_DIV  = 2'd2
   } state_e;

   // Order matches funct[1:0] of the mult/multu/div/divu group.
   typedef enum logic [1:0] {
      MD_MULT  = 2'd0,
      MD_MULTU = 2'd1,
      MD_DIV   = 2'd2,
      MD_DIVU  = 2'd3
   } md_op_e;

   function automatic logic is_fn(input logic [31:0] ins, input logic [5:0] fn);
      return (ins[31:26] == c_OP_SPECIAL) && (ins[5:0] == fn);
   endfunction

   function automatic logic is_muldiv(input logic [31:0] ins);
      return is_fn(ins, c_FN_MULT) || is_fn(ins, c_FN_MULTU) ||
             is_fn(ins, c_FN_DIV)  || is_fn(ins, c_FN_DIVU);
   endfunction

   function automatic logic is_md(input logic [31:0] ins);
      return is_muldiv(ins) ||
             is_fn(ins, c_FN_MFHI) || is_fn(ins, c_FN_MTHI) ||
             is_fn(ins, c_FN_MFLO) || is_fn(ins, c_FN_MTLO);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : mdu_ctrl_if
// Brief  : Pipeline-side signal bundle between the core and the MDU controller
// Rev    : 1.0  initial release
// ============================================================================
interface mdu_ctrl_if;
   logic [31:0] InsD;
   logic [31:0] InsE;
   logic [31:0] RsE;
   logic [31:0] RtE;
   logic        start;
   logic        busy;
   logic        stall;
   logic [31:0] HI;
   logic [31:0] LO;

   modport master (
      output InsD, InsE, RsE, RtE,
      input  start, busy, stall, HI, LO
   );

   modport slave (
      input  InsD, InsE, RsE, RtE,
      output start, busy, stall, HI, LO
   );
endinterface
`default_nettype wire

// File: rtl/mdu_alu.sv
`default_nettype none
// ============================================================================
// Module : mdu_alu
// Brief  : Combinational multiply/divide datapath producing HI/LO and div0 flag
// Rev    : 1.0  initial release
// ============================================================================
module mdu_alu
   import mdu_ctrl_pkg::*;
(
   input  md_op_e      i_op,
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   output logic [31:0] o_hi,
   output logic [31:0] o_lo,
   output logic        o_div0
);

   logic        w_signed;
   logic [31:0] w_a_mag;
   logic [31:0] w_b_mag;
   logic [31:0] w_b_div;
   logic [31:0] w_q_mag;
   logic [31:0] w_r_mag;
   logic [31:0] w_q;
   logic [31:0] w_r;
   logic [63:0] w_prod_s;
   logic [63:0] w_prod_u;

   // Sign-extended operands give the two's-complement product modulo 2^64.
   assign w_prod_s = {{32{i_a[31]}}, i_a} * {{32{i_b[31]}}, i_b};
   assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

   // Signed divide on magnitudes avoids the INT_MIN / -1 overflow corner.
   assign w_signed = (i_op == MD_DIV);
   assign w_a_mag  = (w_signed && i_a[31]) ? (32'd0 - i_a) : i_a;
   assign w_b_mag  = (w_signed && i_b[31]) ? (32'd0 - i_b) : i_b;
   assign w_b_div  = (i_b == 32'd0) ? 32'd1 : w_b_mag;
   assign w_q_mag  = w_a_mag / w_b_div;
   assign w_r_mag  = w_a_mag % w_b_div;
   assign w_q      = (w_signed && (i_a[31] ^ i_b[31])) ? (32'd0 - w_q_mag) : w_q_mag;
   assign w_r      = (w_signed && i_a[31]) ? (32'd0 - w_r_mag) : w_r_mag;

   assign o_div0 = ((i_op == MD_DIV) || (i_op == MD_DIVU)) && (i_b == 32'd0);

   always_comb begin
      {o_hi, o_lo} = {w_r, w_q};
      case (i_op)
         MD_MULT:  {o_hi, o_lo} = w_prod_s;
         MD_MULTU: {o_hi, o_lo} = w_prod_u;
         default:  {o_hi, o_lo} = {w_r, w_q};
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module : mdu_ctrl
// Brief  : Multi-cycle MDU sequencer with HI/LO registers and D-stage stall
// Rev    : 1.0  initial release
// ============================================================================
module mdu_ctrl
   import mdu_ctrl_pkg::*;
#(
   parameter int MULT_CYC = c_MULT_CYC_DEF,
   parameter int DIV_CYC  = c_DIV_CYC_DEF
)(
   input  logic       clk,
   input  logic       reset,
   mdu_ctrl_if.slave  bus
);

   localparam logic [3:0] c_MULT_LOAD = 4'(MULT_CYC - 1);
   localparam logic [3:0] c_DIV_LOAD  = 4'(DIV_CYC - 1);

   state_e      r_state;
   state_e      w_state_nxt;
   logic [3:0]  r_cnt;
   logic [3:0]  w_cnt_nxt;
   logic [31:0] r_hi;
   logic [31:0] r_lo;
   logic [31:0] r_hi_n;
   logic [31:0] r_lo_n;
   logic        r_wr_n;

   logic        w_busy;
   logic        w_start;
   logic        w_done;
   logic        w_mthi;
   logic        w_mtlo;
   md_op_e      w_op;
   logic [31:0] w_alu_hi;
   logic [31:0] w_alu_lo;
   logic        w_alu_div0;

   assign w_op    = md_op_e'(bus.InsE[1:0]);
   assign w_busy  = (r_state != ST_IDLE);
   assign w_start = is_muldiv(bus.InsE) && !w_busy;
   assign w_done  = w_busy && (r_cnt == 4'd0);
   assign w_mthi  = is_fn(bus.InsE, c_FN_MTHI) && !w_busy;
   assign w_mtlo  = is_fn(bus.InsE, c_FN_MTLO) && !w_busy;

   assign bus.start = w_start;
   assign bus.busy  = w_busy;
   assign bus.stall = is_md(bus.InsD) && (w_start || w_busy);
   assign bus.HI    = r_hi;
   assign bus.LO    = r_lo;

   mdu_alu u_alu (
      .i_op   (w_op),
      .i_a    (bus.RsE),
      .i_b    (bus.RtE),
      .o_hi   (w_alu_hi),
      .o_lo   (w_alu_lo),
      .o_div0 (w_alu_div0)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_IDLE: begin
            if (w_start) begin
               w_state_nxt = bus.InsE[1] ? ST_DIV : ST_MULT;
               w_cnt_nxt   = bus.InsE[1] ? c_DIV_LOAD : c_MULT_LOAD;
            end
         end
         ST_MULT, ST_DIV: begin
            if (r_cnt == 4'd0) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 4'd0;
         end
      endcase
   end

   // A divide by zero still runs its cycles but its result is never committed.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_hi   <= 32'd0;
         r_lo   <= 32'd0;
         r_hi_n <= 32'd0;
         r_lo_n <= 32'd0;
         r_wr_n <= 1'b0;
      end else begin
         if (w_start) begin
            r_hi_n <= w_alu_hi;
            r_lo_n <= w_alu_lo;
            r_wr_n <= !w_alu_div0;
         end
         if (w_done) begin
            if (r_wr_n) begin
               r_hi <= r_hi_n;
               r_lo <= r_lo_n;
            end
         end else begin
            if (w_mthi) r_hi <= bus.RsE;
            if (w_mtlo) r_lo <= bus.RsE;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_mdu_ctrl
// Brief  : Directed scoreboard bench for the MDU controller
// Rev    : 1.0  initial release
// ============================================================================
module tb_mdu_ctrl;
   import mdu_ctrl_pkg::*;

   localparam logic [31:0] I_MULT  = 32'h01090018;
   localparam logic [31:0] I_MULTU = 32'h01090019;
   localparam logic [31:0] I_DIV   = 32'h0109001A;
   localparam logic [31:0] I_DIVU  = 32'h0109001B;
   localparam logic [31:0] I_MFLO  = 32'h00005012;
   localparam logic [31:0] I_MTHI  = 32'h01000011;
   localparam logic [31:0] I_MTLO  = 32'h01000013;
   localparam logic [31:0] I_ADD   = 32'h01095020;

   typedef struct {
      string       name;
      logic [31:0] hi;
      logic [31:0] lo;
      int          cyc;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   mdu_ctrl_if bus ();

   mdu_ctrl #(
      .MULT_CYC (5),
      .DIV_CYC  (10)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every busy 1->0 transition outside reset is a completion.
   int   busy_run  = 0;
   logic prev_busy = 1'b0;
   always @(negedge clk) begin : monitor
      exp_t e;
      if (!reset) begin
         busy_run  = 0;
         prev_busy = 1'b0;
      end else begin
         if (bus.busy) begin
            busy_run++;
         end else if (prev_busy) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_completion: got completion expected none");
            end else begin
               e = sb.pop_front();
               chk({e.name, "_HI"},   bus.HI, e.hi);
               chk({e.name, "_LO"},   bus.LO, e.lo);
               chk({e.name, "_busy_cycles"}, 32'(busy_run), 32'(e.cyc));
            end
            busy_run = 0;
         end
         prev_busy = bus.busy;
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Present an instruction in E for exactly one cycle.
   task automatic drive_e(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt,
                          input logic exp_start, input logic exp_stall, input string name);
      bus.InsE = ins;
      bus.RsE  = rs;
      bus.RtE  = rt;
      @(negedge clk);
      chk({name, "_start"}, {31'd0, bus.start}, {31'd0, exp_start});
      chk({name, "_stall"}, {31'd0, bus.stall}, {31'd0, exp_stall});
      next_cycle();
      bus.InsE = 32'd0;
   endtask

   task automatic wait_sb();
      int n = 0;
      while (sb.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL timeout: %0d results pending expected 0", sb.size());
         sb.delete();
      end
      next_cycle();
   endtask

   initial begin
      bus.InsD = 32'd0;
      bus.InsE = 32'd0;
      bus.RsE  = 32'd0;
      bus.RtE  = 32'd0;
      #2 reset = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_HI",    bus.HI, 32'd0);
      chk("reset_LO",    bus.LO, 32'd0);
      chk("reset_busy",  {31'd0, bus.busy},  32'd0);
      chk("reset_start", {31'd0, bus.start}, 32'd0);
      chk("reset_stall", {31'd0, bus.stall}, 32'd0);

      // mult issued in the very first cycle after reset release, mflo waiting in D
      @(posedge clk);
      #1;
      reset    = 1'b1;
      bus.InsD = I_MFLO;
      sb.push_back('{"mult", 32'hFFFFFFFF, 32'hFFFFFFFA, 5});
      drive_e(I_MULT, 32'hFFFFFFFE, 32'd3, 1'b1, 1'b1, "mult");
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         chk("mult_stall_busy", {31'd0, bus.stall}, 32'd1);
         next_cycle();
      end
      @(negedge clk);
      chk("mult_stall_release", {31'd0, bus.stall}, 32'd0);
      next_cycle();
      bus.InsD = 32'd0;
      wait_sb();

      // multu with a non-MDU add in D
      bus.InsD = I_ADD;
      sb.push_back('{"multu", 32'h00000002, 32'hFFFFFFFA, 5});
      drive_e(I_MULTU, 32'hFFFFFFFE, 32'd3, 1'b1, 1'b0, "multu");
      @(negedge clk);
      chk("add_busy",  {31'd0, bus.busy},  32'd1);
      chk("add_stall", {31'd0, bus.stall}, 32'd0);
      next_cycle();
      bus.InsD = 32'd0;
      wait_sb();

      sb.push_back('{"div", 32'hFFFFFFFF, 32'hFFFFFFFD, 10});
      drive_e(I_DIV, 32'hFFFFFFF9, 32'd2, 1'b1, 1'b0, "div");
      wait_sb();

      // divide by zero leaves the previous HI/LO in place
      sb.push_back('{"div0", 32'hFFFFFFFF, 32'hFFFFFFFD, 10});
      drive_e(I_DIV, 32'h80000000, 32'd0, 1'b1, 1'b0, "div0");
      wait_sb();

      sb.push_back('{"div_ovf", 32'h00000000, 32'h80000000, 10});
      drive_e(I_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, "div_ovf");
      wait_sb();

      sb.push_back('{"divu", 32'h00000001, 32'h7FFFFFFC, 10});
      drive_e(I_DIVU, 32'hFFFFFFF9, 32'd2, 1'b1, 1'b0, "divu");
      wait_sb();

      drive_e(I_MTHI, 32'hCAFEF00D, 32'd0, 1'b0, 1'b0, "mthi");
      @(negedge clk);
      chk("mthi_HI", bus.HI, 32'hCAFEF00D);
      chk("mthi_LO", bus.LO, 32'h7FFFFFFC);
      next_cycle();
      drive_e(I_MTLO, 32'h12345678, 32'd0, 1'b0, 1'b0, "mtlo");
      @(negedge clk);
      chk("mtlo_LO", bus.LO, 32'h12345678);
      chk("mtlo_HI", bus.HI, 32'hCAFEF00D);
      next_cycle();

      drive_e(I_ADD, 32'd5, 32'd6, 1'b0, 1'b0, "add_e");
      @(negedge clk);
      chk("add_e_busy", {31'd0, bus.busy}, 32'd0);
      next_cycle();

      // a div reaching E while a mult is busy must be dropped
      sb.push_back('{"mult_small", 32'h00000000, 32'h0000002A, 5});
      drive_e(I_MULT, 32'd6, 32'd7, 1'b1, 1'b0, "mult_small");
      drive_e(I_DIV, 32'd7, 32'd2, 1'b0, 1'b0, "div_ignored");
      wait_sb();
      repeat (12) @(negedge clk);
      chk("ignored_busy", {31'd0, bus.busy}, 32'd0);
      chk("ignored_HI", bus.HI, 32'h00000000);
      chk("ignored_LO", bus.LO, 32'h0000002A);
      next_cycle();

      // reset in the middle of a divu aborts it
      drive_e(I_DIVU, 32'd100, 32'd7, 1'b1, 1'b0, "divu_abort");
      next_cycle();
      next_cycle();
      reset = 1'b0;
      @(negedge clk);
      chk("abort_busy", {31'd0, bus.busy}, 32'd0);
      chk("abort_HI", bus.HI, 32'd0);
      chk("abort_LO", bus.LO, 32'd0);
      next_cycle();
      reset = 1'b1;
      drive_e(I_MTLO, 32'h00001234, 32'd0, 1'b0, 1'b0, "mtlo_post");
      @(negedge clk);
      chk("post_LO", bus.LO, 32'h00001234);
      chk("post_HI", bus.HI, 32'd0);
      repeat (12) @(negedge clk);
      chk("post_busy", {31'd0, bus.busy}, 32'd0);
      chk("post_pending", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
